// File: rtl/jk_universal_pkg.sv
// Shared types and constants for the JK-cell universal register.
// The helper folds MODULUS-1 down to the register width used by the counter.
package jk_universal_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_ROTL = 2'b11
  } jk_mode_t;

  // Terminal count (MODULUS-1) truncated to 'width' bits.
  function automatic logic [31:0] mod_max(input int unsigned width,
                                          input longint unsigned modulus);
    longint unsigned mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((modulus - 64'd1) & mask);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One register bit: synchronous clear/preset, parallel load, otherwise JK behaviour.
// Priority inside the cell is rst > clr > pre > ld > JK.
module jk_cell
  import jk_universal_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic pre,
  input  logic pre_val,
  input  logic ld,
  input  logic d,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  // Bit state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (clr) begin
      q_q <= 1'b0;
    end else if (pre) begin
      q_q <= pre_val;
    end else if (ld) begin
      q_q <= d;
    end else begin
      case ({j, k})
        2'b00:   q_q <= q_q;
        2'b10:   q_q <= 1'b1;
        2'b01:   q_q <= 1'b0;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_universal_reg.sv
// WIDTH-bit register of JK cells with JK, mod-N up/down count and rotate-left modes.
// The top computes load data for count/rotate/hold and owns the wrap flag.
module jk_universal_reg
  import jk_universal_pkg::*;
#(
  parameter int unsigned       WIDTH      = 4,
  parameter longint unsigned   MODULUS    = 64'd1 << WIDTH,
  parameter logic [WIDTH-1:0]  PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             pre,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             wrap
);

  localparam logic [31:0]      MAX32_C = mod_max(WIDTH, MODULUS);
  localparam logic [WIDTH-1:0] MAX_C   = MAX32_C[WIDTH-1:0];

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] rot_s;
  logic [WIDTH-1:0] ld_data_d;
  logic             ld_s;
  logic             wrap_d;
  logic             wrap_q;
  jk_mode_t         mode_s;

  assign mode_s = jk_mode_t'(mode);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      // Modulo index makes WIDTH=1 rotate onto itself, i.e. hold.
      assign rot_s[gi] = q_s[(gi + WIDTH - 1) % WIDTH];

      jk_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .pre     (pre),
        .pre_val (PRESET_VAL[gi]),
        .ld      (ld_s),
        .d       (ld_data_d[gi]),
        .j       (j[gi]),
        .k       (k[gi]),
        .q       (q_s[gi])
      );
    end
  endgenerate

  // Next-state selection for the non-JK paths; en=0 reloads the current value.
  always_comb begin
    ld_s      = 1'b1;
    ld_data_d = q_s;
    wrap_d    = 1'b0;
    if (!en) begin
      ld_s      = 1'b1;
      ld_data_d = q_s;
    end else begin
      case (mode_s)
        MODE_JK: begin
          ld_s = 1'b0;
        end
        MODE_UP: begin
          if (q_s >= MAX_C) begin
            ld_data_d = {WIDTH{1'b0}};
            wrap_d    = 1'b1;
          end else begin
            ld_data_d = q_s + WIDTH'(1'b1);
          end
        end
        MODE_DOWN: begin
          if (q_s == {WIDTH{1'b0}}) begin
            ld_data_d = MAX_C;
            wrap_d    = 1'b1;
          end else if (q_s > MAX_C) begin
            ld_data_d = MAX_C;
          end else begin
            ld_data_d = q_s - WIDTH'(1'b1);
          end
        end
        MODE_ROTL: begin
          ld_data_d = rot_s;
        end
        default: begin
          ld_data_d = q_s;
        end
      endcase
    end
  end

  // Wrap flag, cleared by any reset/clear/preset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else if (clr || pre) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_s;
  assign qbar = ~q_s;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_universal_reg.sv
// Table-driven scoreboard bench for jk_universal_reg (MODULUS=10), plus a
// hand-written MODULUS=2 sequence on a second instance.
module tb_jk_universal_reg;
  import jk_universal_pkg::*;

  typedef struct {
    logic       rst, en, clr, pre;
    logic [1:0] mode;
    logic [3:0] j, k;
    logic [3:0] eq;
    logic       ew;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, clr, pre;
  logic [1:0] mode;
  logic [3:0] j, k, q, qbar;
  logic       wrap;

  logic       rst2, en2;
  logic [1:0] mode2;
  logic [3:0] q2, qbar2;
  logic       wrap2;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  jk_universal_reg #(.WIDTH(4), .MODULUS(64'd10), .PRESET_VAL(4'hF)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .pre(pre), .mode(mode),
    .j(j), .k(k), .q(q), .qbar(qbar), .wrap(wrap)
  );

  jk_universal_reg #(.WIDTH(4), .MODULUS(64'd2), .PRESET_VAL(4'hF)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .clr(1'b0), .pre(1'b0), .mode(mode2),
    .j(4'h0), .k(4'h0), .q(q2), .qbar(qbar2), .wrap(wrap2)
  );

  function automatic vec_t mk(logic r, logic e, logic c, logic p, logic [1:0] m,
                              logic [3:0] jj, logic [3:0] kk, logic [3:0] eq, logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.pre = p; v.mode = m;
    v.j = jj; v.k = kk; v.eq = eq; v.ew = ew;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    exp_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; clr = v.clr; pre = v.pre;
    mode = v.mode; j = v.j; k = v.k;
    e.q = v.eq; e.w = v.ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("q[%0d]", idx), q, e.q);
      check($sformatf("qbar[%0d]", idx), qbar, ~e.q);
      check($sformatf("wrap[%0d]", idx), {3'b000, wrap}, {3'b000, e.w});
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; pre = 1'b0; mode = 2'b00; j = 4'h0; k = 4'h0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = MODE_UP;

    // Reset, preset, clear-beats-preset
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, MODE_JK, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, MODE_JK, 4'h0, 4'h0, 4'hF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, MODE_JK, 4'h0, 4'h0, 4'h0, 1'b0));
    // JK mode
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'hA, 4'h0, 4'hA, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'h0, 4'h2, 4'h8, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'hF, 4'hF, 4'h7, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'h0, 4'h0, 4'h7, 1'b0));
    // UP 0..9, wrap, wrap drops after one cycle
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'(i), 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h1, 1'b0));
    // Out-of-range 13 then UP wraps
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'hC, 4'h0, 4'hD, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b1));
    // DOWN from 0, then from out-of-range 12
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_DOWN, 4'h0, 4'h0, 4'h9, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_DOWN, 4'h0, 4'h0, 4'h8, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'h4, 4'h0, 4'hC, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_DOWN, 4'h0, 4'h0, 4'h9, 1'b0));
    // ROTL from 0001
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, MODE_JK, 4'h0, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_JK, 4'h1, 4'h0, 4'h1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_ROTL, 4'h0, 4'h0, 4'h2, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_ROTL, 4'h0, 4'h0, 4'h4, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_ROTL, 4'h0, 4'h0, 4'h8, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_ROTL, 4'h0, 4'h0, 4'h1, 1'b0));
    // en=0 holds (JK inputs live), then preset ignores en
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, MODE_UP, 4'hF, 4'hF, 4'h1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'hF, 1'b0));
    // Reset mid-count at 5, then resume
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'(i), 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, MODE_UP, 4'hF, 4'h0, 4'h0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h2, 1'b0));
    // Count to 9, then clr on the would-wrap edge: no wrap
    for (int i = 3; i <= 9; i++)
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, MODE_UP, 4'h0, 4'h0, 4'(i), 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // MODULUS=2: reset, then wrap on every second UP edge
    @(negedge clk);
    rst2 = 1'b1; en2 = 1'b1;
    @(posedge clk);
    #1;
    check("m2_reset_q", q2, 4'h0);
    check("m2_reset_wrap", {3'b000, wrap2}, 4'h0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("m2_q[%0d]", n), q2, (n % 2 == 1) ? 4'h1 : 4'h0);
      check($sformatf("m2_qbar[%0d]", n), qbar2, (n % 2 == 1) ? 4'hE : 4'hF);
      check($sformatf("m2_wrap[%0d]", n), {3'b000, wrap2}, (n % 2 == 0) ? 4'h1 : 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
